// File: rtl/btn_pkg.sv
// Shared constants and state encoding for the front-panel key debouncer.
// Imported by the debouncer RTL, the transaction FSM and the benches.
package btn_pkg;

  localparam int unsigned DEF_N_BTN      = 4;
  localparam int unsigned DEF_DEB_CYCLES = 50000;
  localparam int unsigned DEF_CNT_W      = 16;

  typedef enum logic [1:0] {
    IDLE_LO = 2'b00,
    WAIT_HI = 2'b01,
    IDLE_HI = 2'b10,
    WAIT_LO = 2'b11
  } deb_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One key: 2-flop synchroniser, counter debouncer, press/release pulses.
// press_nxt_o exposes next-cycle press so the top can register any_press.
module debounce_channel
  import btn_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic press_nxt_o
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic       s1_q;
  logic       s2_q;
  deb_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       level_q, level_d;
  logic       press_q, press_d;
  logic       release_q, release_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q ^ ACTIVE_LOW;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      IDLE_LO: begin
        cnt_d = '0;
        if (s2_q) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HI: begin
        if (!s2_q) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      IDLE_HI: begin
        cnt_d = '0;
        if (!s2_q) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LO: begin
        // Any high sample restarts the hold; the count never passes CNT_LAST
        if (s2_q) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE_LO;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE_LO;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o     = level_q;
  assign press_o     = press_q;
  assign release_o   = release_q;
  assign press_nxt_o = press_d;

endmodule

// File: rtl/btn_debounce_sync.sv
// Front-panel key conditioning: N_BTN independent debounce channels
// plus a registered any_press aligned with the per-key press pulses.
module btn_debounce_sync
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN      = DEF_N_BTN,
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             any_press
);

  logic [N_BTN-1:0] press_nxt;
  logic             any_press_q, any_press_d;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    debounce_channel #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_ch (
      .clk_i       (clk),
      .rst_i       (rst),
      .raw_i       (btn_raw[i]),
      .level_o     (btn_level[i]),
      .press_o     (btn_press[i]),
      .release_o   (btn_release[i]),
      .press_nxt_o (press_nxt[i])
    );
  end

  assign any_press_d = |press_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      any_press_q <= 1'b0;
    end else begin
      any_press_q <= any_press_d;
    end
  end

  assign any_press = any_press_q;

endmodule

// File: tb/tb_btn_debounce_sync.sv
// Directed bench for btn_debounce_sync with DEB_CYCLES=4, CNT_W=3.
// Two instances: active-high keys and active-low keys.
module tb_btn_debounce_sync;

  logic       clk;
  logic       rst;
  logic [3:0] raw;
  logic [3:0] raw_n;
  logic [3:0] lvl, prs, rel;
  logic       anyp;
  logic [3:0] lvl_n, prs_n, rel_n;
  logic       anyp_n;

  int checks;
  int failures;

  btn_debounce_sync #(
    .N_BTN(4), .DEB_CYCLES(4), .CNT_W(3), .ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(raw),
    .btn_level(lvl), .btn_press(prs),
    .btn_release(rel), .any_press(anyp)
  );

  btn_debounce_sync #(
    .N_BTN(4), .DEB_CYCLES(4), .CNT_W(3), .ACTIVE_LOW(1'b1)
  ) dut_n (
    .clk(clk), .rst(rst), .btn_raw(raw_n),
    .btn_level(lvl_n), .btn_press(prs_n),
    .btn_release(rel_n), .any_press(anyp_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs were just set at a negedge; the next posedge captures them.
  // Stable input => outputs switch after the 6th following negedge.
  task automatic window(input string tag,
                        input logic [3:0] lv0, lv1, pe, re,
                        input bit cn,
                        input logic [3:0] nlv0, nlv1, npe);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk({tag, "_lvl"}, 32'(lvl), 32'(c >= 6 ? lv1 : lv0));
      chk({tag, "_prs"}, 32'(prs), 32'(c == 6 ? pe : 4'h0));
      chk({tag, "_rel"}, 32'(rel), 32'(c == 6 ? re : 4'h0));
      chk({tag, "_any"}, 32'(anyp), 32'(c == 6 && pe != 4'h0));
      if (cn) begin
        chk({tag, "_nlvl"}, 32'(lvl_n), 32'(c >= 6 ? nlv1 : nlv0));
        chk({tag, "_nprs"}, 32'(prs_n), 32'(c == 6 ? npe : 4'h0));
        chk({tag, "_nany"}, 32'(anyp_n), 32'(c == 6 && npe != 4'h0));
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst   = 1'b1;
    raw   = 4'h0;
    raw_n = 4'hF;
    #1;
    chk("rst0_lvl", 32'(lvl), 32'h0);
    chk("rst0_any", 32'(anyp), 32'h0);
    repeat (3) @(negedge clk);
    chk("rst_lvl", 32'(lvl), 32'h0);
    chk("rst_prs", 32'(prs), 32'h0);
    chk("rst_rel", 32'(rel), 32'h0);
    chk("rst_nlvl", 32'(lvl_n), 32'h0);
    rst = 1'b0;

    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("idle_lvl", 32'(lvl), 32'h0);
      chk("idle_prs", 32'(prs), 32'h0);
      chk("idle_nlvl", 32'(lvl_n), 32'h0);
      chk("idle_nprs", 32'(prs_n), 32'h0);
    end

    raw = 4'b0001;
    window("press0", 4'h0, 4'h1, 4'h1, 4'h0,
           1'b1, 4'h0, 4'h0, 4'h0);

    raw = 4'b0011;
    repeat (3) begin
      @(negedge clk);
      chk("glitch_prs", 32'(prs), 32'h0);
    end
    raw = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("glitch_lvl", 32'(lvl), 32'h1);
      chk("glitch_prs", 32'(prs), 32'h0);
      chk("glitch_any", 32'(anyp), 32'h0);
    end

    for (int b = 0; b < 4; b++) begin
      raw[2] = (b % 2 == 0);
      @(negedge clk);
      chk("bounce_prs", 32'(prs), 32'h0);
      chk("bounce_lvl", 32'(lvl), 32'h1);
    end
    raw[2] = 1'b1;
    window("bounce", 4'h1, 4'h5, 4'h4, 4'h0,
           1'b0, 4'h0, 4'h0, 4'h0);

    raw = 4'b0100;
    window("rel0", 4'h5, 4'h4, 4'h0, 4'h1,
           1'b0, 4'h0, 4'h0, 4'h0);
    raw = 4'b0000;
    window("rel2", 4'h4, 4'h0, 4'h0, 4'h4,
           1'b0, 4'h0, 4'h0, 4'h0);

    raw   = 4'b1011;
    raw_n = 4'b0100;
    window("simul", 4'h0, 4'hB, 4'hB, 4'h0,
           1'b1, 4'h0, 4'hB, 4'hB);

    rst = 1'b1;
    #1;
    chk("arst_lvl", 32'(lvl), 32'h0);
    chk("arst_nlvl", 32'(lvl_n), 32'h0);
    chk("arst_prs", 32'(prs), 32'h0);
    @(negedge clk);
    chk("arst_hold", 32'(lvl), 32'h0);
    rst = 1'b0;
    window("rstwin", 4'h0, 4'hB, 4'hB, 4'h0,
           1'b0, 4'h0, 4'h0, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
